// File: rtl/frame_sync_pkg.sv
// frame_sync shared types and default frame geometry.
// Sizing helper keeps counter widths sane for tiny parameter values.
package frame_sync_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int SYNC_LEN_DEF  = 4;
    localparam int FRAME_LEN_DEF = 36;
    localparam int WORD_DEF      = 8;
    localparam int CONFIRM_DEF   = 2;
    localparam int MISS_MAX_DEF  = 2;

    localparam int P               = FRAME_LEN_DEF - SYNC_LEN_DEF;
    localparam int WORDS_PER_FRAME = P / WORD_DEF;
    localparam int CNT_W           = $clog2(FRAME_LEN_DEF);

    function automatic int width_for(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_sync_if.sv
// Serial-in / word-out bundle between sync detector and frame_sync.
interface frame_sync_if #(
    parameter int WORD = 8
);
    logic            bit_vld;
    logic            bit_in;
    logic            sync_hit;
    logic            locked;
    logic [WORD-1:0] word_out;
    logic            word_valid;
    logic            word_first;
    logic            sync_err;

    modport master (
        output bit_vld, bit_in, sync_hit,
        input  locked, word_out, word_valid, word_first, sync_err
    );

    modport slave (
        input  bit_vld, bit_in, sync_hit,
        output locked, word_out, word_valid, word_first, sync_err
    );
endinterface

// File: rtl/frame_deser.sv
// MSB-first payload shifter with registered word output and strobe.
module frame_deser
    import frame_sync_pkg::*;
#(
    parameter int WORD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            shift_en,
    input  logic            clear,
    input  logic            bit_in,
    input  logic            first_in,
    output logic [WORD-1:0] word_out,
    output logic            word_valid,
    output logic            word_first
);

    localparam int BW = width_for(WORD);
    localparam logic [BW-1:0] BLAST = BW'(WORD - 1);

    logic [WORD-1:0] sh_q, sh_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [WORD-1:0] word_q, word_d;
    logic            valid_q, valid_d;
    logic            first_q, first_d;

    always_comb begin
        sh_d    = sh_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        valid_d = 1'b0;
        first_d = 1'b0;
        if (clear) begin
            sh_d   = '0;
            bcnt_d = '0;
        end else if (shift_en) begin
            sh_d = {sh_q[WORD-2:0], bit_in};
            if (bcnt_q == BLAST) begin
                bcnt_d  = '0;
                word_d  = sh_d;
                valid_d = 1'b1;
                first_d = first_in;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q    <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            first_q <= first_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign word_first = first_q;

endmodule

// File: rtl/frame_sync.sv
// Hunt/verify/locked frame aligner with flywheel, feeding frame_deser.
module frame_sync
    import frame_sync_pkg::*;
#(
    parameter int SYNC_LEN  = SYNC_LEN_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int WORD      = WORD_DEF,
    parameter int CONFIRM   = CONFIRM_DEF,
    parameter int MISS_MAX  = MISS_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst,
    frame_sync_if.slave  bus
);

    localparam int PAY = FRAME_LEN - SYNC_LEN;
    localparam int CW  = width_for(FRAME_LEN);
    localparam int HW  = width_for(CONFIRM + 1);
    localparam int MW  = width_for(MISS_MAX + 1);

    localparam logic [CW-1:0] LAST  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] PEND  = CW'(PAY);
    localparam logic [CW-1:0] WLAST = CW'(WORD - 1);
    localparam logic [HW-1:0] HCONF = HW'(CONFIRM);
    localparam logic [MW-1:0] MMAX  = MW'(MISS_MAX);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hits_q, hits_d, hits_inc;
    logic [MW-1:0] miss_q, miss_d, miss_inc;
    logic          err_q, err_d;
    logic          at_sync;
    logic          shift_en;
    logic          clear;
    logic          first;

    assign at_sync  = (cnt_q == LAST);
    assign hits_inc = hits_q + HW'(1);
    assign miss_inc = miss_q + MW'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hits_d   = hits_q;
        miss_d   = miss_q;
        err_d    = 1'b0;
        shift_en = 1'b0;
        first    = 1'b0;
        clear    = (state_q != LOCKED);
        if (bus.bit_vld) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.sync_hit) begin
                        cnt_d   = '0;
                        hits_d  = HW'(1);
                        miss_d  = '0;
                        state_d = (CONFIRM == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (!at_sync) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (bus.sync_hit) begin
                        cnt_d  = '0;
                        hits_d = hits_inc;
                        if (hits_inc >= HCONF) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        cnt_d   = '0;
                        hits_d  = '0;
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    shift_en = (cnt_q < PEND);
                    first    = (cnt_q == WLAST);
                    if (!at_sync) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (bus.sync_hit) begin
                        cnt_d  = '0;
                        miss_d = '0;
                    end else begin
                        // Flywheel: keep the frame grid, only give up after MISS_MAX
                        cnt_d = '0;
                        err_d = 1'b1;
                        if (miss_inc >= MMAX) begin
                            miss_d  = '0;
                            hits_d  = '0;
                            state_d = HUNT;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = '0;
                    hits_d  = '0;
                    miss_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            hits_q  <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hits_q  <= hits_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    frame_deser #(
        .WORD(WORD)
    ) u_deser (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .clear     (clear),
        .bit_in    (bus.bit_in),
        .first_in  (first),
        .word_out  (bus.word_out),
        .word_valid(bus.word_valid),
        .word_first(bus.word_first)
    );

    assign bus.locked   = (state_q == LOCKED);
    assign bus.sync_err = err_q;

endmodule

// File: tb/tb_frame_sync.sv
// Directed bench for frame_sync: per-bit lock/err vectors plus word tables.
module tb_frame_sync;
    import frame_sync_pkg::*;

    typedef struct {
        logic b;
        logic h;
        logic xl;
        logic xe;
    } vec_t;

    typedef struct {
        logic [7:0] w;
        logic       f;
        int         at;
    } wrec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_sync_if #(.WORD(8)) bus();

    frame_sync #(
        .SYNC_LEN (4),
        .FRAME_LEN(36),
        .WORD     (8),
        .CONFIRM  (2),
        .MISS_MAX (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    vec_t  vec[200];
    int    nvec;
    wrec_t wexp[$];
    wrec_t wgot[$];
    int    n_chk;
    int    n_fail;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic clear_vec(input int n);
        for (int i = 0; i < 200; i++) vec[i] = '{b: 1'b0, h: 1'b0, xl: 1'b0, xe: 1'b0};
        nvec = n;
        wexp.delete();
    endtask

    // Writes 4 payload bytes MSB-first from bit s; queues expected words if locked.
    task automatic frame(input int s, input logic [31:0] pl, input logic lk);
        logic [31:0] v;
        v = pl;
        for (int i = 0; i < 32; i++) vec[s+i].b = v[31-i];
        if (lk) begin
            for (int j = 0; j < 4; j++) begin
                wexp.push_back('{w: v[31-8*j -: 8], f: (j == 0), at: s + 8*j + 7});
            end
        end
    endtask

    task automatic exp_lock(input int a, input int b);
        for (int k = a; k <= b; k++) vec[k].xl = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " locked"}, bus.locked, 0);
        chk({tag, " word_out"}, bus.word_out, 0);
        chk({tag, " word_valid"}, bus.word_valid, 0);
        chk({tag, " word_first"}, bus.word_first, 0);
        chk({tag, " sync_err"}, bus.sync_err, 0);
    endtask

    task automatic do_reset();
        bus.bit_vld = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run(input int gap_every, input int gap_len, input string tag);
        int stray;
        int n;
        stray = 0;
        wgot.delete();
        for (int k = 0; k < nvec; k++) begin
            bus.bit_vld  = 1'b1;
            bus.bit_in   = vec[k].b;
            bus.sync_hit = vec[k].h;
            @(posedge clk);
            #1;
            chk($sformatf("%s locked@%0d", tag, k), bus.locked, vec[k].xl);
            chk($sformatf("%s sync_err@%0d", tag, k), bus.sync_err, vec[k].xe);
            if (bus.word_valid === 1'b1) begin
                wgot.push_back('{w: bus.word_out, f: bus.word_first, at: k});
            end
            if (gap_every > 0 && (k % gap_every) == gap_every - 1) begin
                for (int g = 0; g < gap_len; g++) begin
                    bus.bit_vld  = 1'b0;
                    bus.bit_in   = 1'($urandom);
                    bus.sync_hit = 1'b1;
                    @(posedge clk);
                    #1;
                    if (bus.word_valid !== 1'b0 || bus.sync_err !== 1'b0) stray++;
                    if (bus.locked !== vec[k].xl) stray++;
                end
            end
        end
        bus.bit_vld  = 1'b0;
        bus.sync_hit = 1'b0;
        chk({tag, " gap strobes"}, stray, 0);
        chk({tag, " word count"}, wgot.size(), wexp.size());
        n = (wgot.size() < wexp.size()) ? wgot.size() : wexp.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s word%0d data", tag, i), wgot[i].w, wexp[i].w);
            chk($sformatf("%s word%0d first", tag, i), wgot[i].f, wexp[i].f);
            chk($sformatf("%s word%0d bit", tag, i), wgot[i].at, wexp[i].at);
        end
    endtask

    task automatic build_acq();
        clear_vec(80);
        vec[3].h  = 1'b1;
        vec[39].h = 1'b1;
        vec[75].h = 1'b1;
        exp_lock(39, 79);
        frame(40, 32'hA53C_FF01, 1'b1);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        bus.bit_vld = 1'b0;
        bus.bit_in = 1'b0;
        bus.sync_hit = 1'b0;
        rst = 1'b1;
        #1;
        check_idle("reset");
        #20;
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-word while locked
        build_acq();
        nvec = 52;
        while (wexp.size() > 1) void'(wexp.pop_back());
        run(0, 0, "rst_pre");
        #2 rst = 1'b1;
        #1;
        check_idle("rst_mid");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_vec(45);
        frame(4, 32'hFFFF_FFFF, 1'b0);
        run(0, 0, "rst_post");

        do_reset();
        build_acq();
        run(0, 0, "acq");

        do_reset();
        clear_vec(90);
        vec[3].h  = 1'b1;
        vec[50].h = 1'b1;
        vec[86].h = 1'b1;
        frame(4, 32'hDEAD_BEEF, 1'b0);
        frame(51, 32'h1234_5678, 1'b0);
        exp_lock(86, 89);
        run(0, 0, "false");

        // One miss, spurious hits, recovery, then a lone second miss
        do_reset();
        clear_vec(155);
        vec[3].h   = 1'b1;
        vec[39].h  = 1'b1;
        vec[73].h  = 1'b1;
        vec[80].h  = 1'b1;
        vec[111].h = 1'b1;
        exp_lock(39, 154);
        vec[75].xe  = 1'b1;
        vec[147].xe = 1'b1;
        frame(40, 32'h1234_5678, 1'b1);
        frame(76, 32'h9ABC_DEF0, 1'b1);
        frame(112, 32'h0F1E_2D3C, 1'b1);
        run(0, 0, "fly");

        do_reset();
        clear_vec(151);
        vec[3].h   = 1'b1;
        vec[39].h  = 1'b1;
        vec[112].h = 1'b1;
        vec[148].h = 1'b1;
        exp_lock(39, 110);
        exp_lock(148, 150);
        vec[75].xe  = 1'b1;
        vec[111].xe = 1'b1;
        frame(40, 32'hCAFE_BABE, 1'b1);
        frame(76, 32'h00FF_55AA, 1'b1);
        frame(113, 32'h7777_7777, 1'b0);
        run(0, 0, "loss");

        do_reset();
        build_acq();
        run(5, 3, "gaps");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_sync.md
Name: frame_sync

Overview:
Downstream consumer of the serial sync-word detector. It takes the detector's per-bit match flag plus the same serial bit stream, and runs a hunt/verify/locked frame-alignment FSM with flywheel tolerance. Once locked, it deserializes each frame's payload into WORD-bit words with a valid strobe. It sits between the sync detector and the word-level receive logic.

Parameters:
SYNC_LEN, 4, sync word length in bits (matches the detector's N)
FRAME_LEN, 36, total bits per frame: SYNC_LEN sync bits followed by payload; (FRAME_LEN-SYNC_LEN) % WORD must be 0
WORD, 8, payload output word width
CONFIRM, 2, consecutive correctly spaced sync hits required to lock (>=1)
MISS_MAX, 2, consecutive missed syncs that drop lock (>=1)

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  asynchronous active-high reset
bit_vld  in  1  a new serial bit is present this cycle (detector shifting, i.e. not loading)
bit_in  in  1  serial bit, same bit the detector shifts in
sync_hit  in  1  qualified by bit_vld: this bit completes a sync word (integrator aligns detector output to this)
locked  out  1  frame alignment held
word_out  out  WORD  deserialized payload word, MSB = first received bit
word_valid  out  1  one-cycle strobe, word_out valid
word_first  out  1  with word_valid: first word of a frame
sync_err  out  1  one-cycle strobe: expected sync missing while locked

Behaviour:
- Async reset: state HUNT, all counters 0, locked/word_out/word_valid/word_first/sync_err = 0. A reset mid-frame discards any partial word.
- Cycles with bit_vld=0: no counter, shift or state change. Strobes still clear.
- P = FRAME_LEN-SYNC_LEN. cnt (clog2(FRAME_LEN) bits) indexes bits after the last sync boundary. cnt=0 is the first payload bit; the next sync is expected at cnt = FRAME_LEN-1.
- HUNT: on bit_vld & sync_hit -> cnt=0, hits=1; go to LOCKED if CONFIRM==1, else VERIFY.
- VERIFY: cnt increments per bit. sync_hit at cnt != FRAME_LEN-1 is ignored.
  - At cnt = FRAME_LEN-1 with hit: hits++, cnt=0; go to LOCKED when hits reaches CONFIRM.
  - At cnt = FRAME_LEN-1 with no hit: go to HUNT, hits=0.
- LOCKED: locked=1. Bits with cnt<P shift into the word shifter MSB-first. Every WORD-th payload bit loads word_out, and word_valid is high for exactly the next cycle (registered, 1-cycle latency from the last bit's edge). word_first=1 on the word with cnt=WORD-1. No words are emitted outside LOCKED.
  - Sync bits (cnt>=P) are not output. sync_hit elsewhere in the frame is ignored.
  - At cnt = FRAME_LEN-1 with hit: misses=0, cnt=0.
  - At cnt = FRAME_LEN-1 with no hit: sync_err pulses next cycle, misses++, cnt=0 (flywheel, payload of the next frame is still emitted). If misses reaches MISS_MAX: go to HUNT, locked=0 from the next cycle, misses=0.
- The first frame delivered is the one following the confirming sync. Lock is lost only at a sync position, so a payload is never truncated except by reset.
- In HUNT, sync_err is never asserted.

Decomposition:
- Shared package frame_sync_pkg holds:
  - state enum {HUNT, VERIFY, LOCKED}
  - localparams P, WORDS_PER_FRAME = P/WORD, CNT_W = $clog2(FRAME_LEN)
- One sub-module, frame_deser. It is a WORD-bit MSB-first shifter with a bit counter and registered word_out/word_valid. It takes shift_en and clear from the FSM.

Test Plan:
Config for all scenarios: SYNC_LEN=4, FRAME_LEN=36, WORD=8, CONFIRM=2, MISS_MAX=2, bit_vld=1 unless stated; bit indices count from 0.
1. Reset: assert rst asynchronously mid-word while LOCKED -> all outputs 0 immediately, state HUNT; after release, no word_valid until re-lock.
2. Acquire: sync_hit at bits 3 and 39; payload bits 40..71 = A5 3C FF 01 -> locked high from the cycle after bit 39. Four word_valid pulses carry 0xA5, 0x3C, 0xFF, 0x01, and only 0xA5 has word_first=1.
3. False start: hit at bit 3, no hit at bit 39, hit at bit 50 -> HUNT at bit 39, VERIFY restarts at bit 50, locked stays 0 throughout, no word_valid.
4. Flywheel: once locked, drop one sync -> one sync_err pulse, locked stays 1, the next frame's 4 words are still emitted. A spurious sync_hit mid-payload has no effect; the next good sync clears misses.
5. Loss: drop two consecutive syncs -> two sync_err pulses 36 bits apart, locked falls the cycle after the second; a hit at the following bit enters VERIFY.
6. Gaps: scenario 2 with bit_vld=0 for 3 cycles inserted every 5 bits -> identical word sequence and flags, only later in time.
